pcihellocore_ir_transmitter: RTL
================================

// Module: pcihellocore_ir_transmitter
// PURPOSE
//  Avalon-MM slave on the pcihellocore fabric that sends 32-bit NEC-format infrared frames.
//  Software writes a code word. The block serializes it as leader, 32 data bits and a stop mark.
//  Each mark is modulated onto a carrier and drives the IR LED pin.
//  It is the transmit counterpart of the IR receiver input port. Status is polled over the same bus.
// PARAMETERS
//  UNIT_CYCLES  28125  clk cycles per NEC base unit (562.5 us at 50 MHz)
//  CARRIER_DIV  1316   clk cycles per carrier period (38 kHz at 50 MHz); high for first CARRIER_DIV/2
//  OUT_INVERT   0      1 = ir_out active-low (idle/space drive 1)
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   asynchronous active-low reset
//  address     in   2   word offset: 0 DATA, 1 STATUS, 2-3 reserved
//  chipselect  in   1   slave select
//  write_n     in   1   active-low write strobe, qualified by chipselect
//  writedata   in   32  write data
//  readdata    out  32  registered read data
//  ir_out      out  1   modulated IR LED drive, registered
//  irq         out  1   frame-done interrupt (only when IR_TX_IRQ_EN is defined)
// BEHAVIOUR
//  Reset (async): readdata=0, ir_out=OUT_INVERT, busy=0, overrun=0, irq=0, FSM=IDLE, all counters 0.
//   A reset in mid-frame aborts immediately. No partial frame resumes.
//  Read path: readdata<=mux(address) every clk, 1-cycle latency.
//   DATA reads the last written word. STATUS reads {29'b0, irq_pend, overrun, busy}. Reserved offsets read 0.
//  DATA write (cs & !write_n & addr==0) while IDLE:
//   - latch word and set busy, with FSM=LEADER_MARK.
//   - ir_out carrier starts on the next cycle (T+1).
//  DATA write while busy: word is dropped, frame is unaffected, overrun<=1 (sticky).
//  STATUS write: writing 1 to bit1 clears overrun and 1 to bit2 clears irq_pend; bit0 is read-only.
//   If a set and a clear of the same flag hit in the same cycle, set wins.
//  FSM: IDLE -> LEADER_MARK(16 units) -> LEADER_SPACE(8) -> BIT_MARK(1) -> BIT_SPACE(1 if bit=0, 3 if bit=1).
//   BIT_MARK/BIT_SPACE repeat 32x, LSB (writedata[0]) first, then STOP_MARK(1) -> IDLE.
//  Unit counter runs 0..UNIT_CYCLES-1. The unit count per state is held in a small down-counter.
//   A 5-bit bit index advances in BIT_SPACE; the exit condition is index==31.
//  Mark states: ir_out = carrier ^ OUT_INVERT. The carrier phase counter restarts at 0 on every mark
//   entry, so each mark begins high. Space and IDLE states: ir_out = OUT_INVERT.
//  busy clears in the cycle IDLE is entered. A DATA write in the final STOP_MARK cycle is an overrun.
//  Frame length = (24 + 1 + sum over bits of 2 or 4 units) * UNIT_CYCLES cycles.
// CONFIGURATION
//  IR_TX_IRQ_EN defined:
//   - irq_pend sets on the STOP_MARK->IDLE transition and drives the irq port (level).
//   - irq_pend is cleared only by a STATUS write of bit2.
//  IR_TX_IRQ_EN undefined: there is no irq port, and STATUS bit2 reads 0 with writes ignored.
// STRUCTURE
//  Package pcihellocore_ir_pkg holds:
//   - FSM state enum (IDLE, LEADER_MARK, LEADER_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK).
//   - Register offsets (DATA=0, STATUS=1) and STATUS bit positions.
//   - NEC unit counts (LEADER_MARK_U=16, LEADER_SPACE_U=8, ZERO_SPACE_U=1, ONE_SPACE_U=3, MARK_U=1).
//  Sub-module pcihellocore_ir_carrier_gen: restartable CARRIER_DIV divider that outputs a 50% duty carrier.
//   The top level holds the Avalon regs, the FSM and the unit timer.
// TESTING (bench params UNIT_CYCLES=8, CARRIER_DIV=4)
//  1 Reset release -> readdata=0, ir_out=0, STATUS=0. Read addr 2/3 -> 0 one cycle after address.
//  2 Write DATA=0x00FFA25D -> busy=1 at T+1. The frame then runs:
//     - leader mark 128 cycles toggling 2 high/2 low, then space 64 cycles.
//     - bit0 mark 8 cycles, space 24 cycles; 16 ones and 16 zeros.
//     - total 968 cycles, then busy=0 and ir_out=0.
//  3 Write DATA=0x12345678 during frame -> frame unchanged, STATUS=0x3. Write STATUS=0x2 -> STATUS=0x1.
//  4 Assert reset_n=0 mid BIT_MARK -> ir_out=0 same cycle. After release, STATUS=0 and a new write sends a full frame.
//  5 Write DATA=0 -> 32 zero bits, frame = (24+64+1)*8 = 712 cycles. Write DATA=0xFFFFFFFF -> 1224 cycles.
//  6 IR_TX_IRQ_EN: irq=1 after frame end, STATUS=0x4. Write STATUS=0x4 -> irq=0. Undefined build: STATUS bit2 stays 0.

Source files
------------

// File: rtl/pcihellocore_ir_pkg.sv
// Shared types and constants for the pcihellocore NEC infrared transmitter.
package pcihellocore_ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEADER_MARK,
    LEADER_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
  } ir_state_e;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_OVERRUN = 1;
  localparam int STAT_IRQ     = 2;

  // NEC timing expressed in base units; the state down-counter is 5 bits wide.
  localparam logic [4:0] LEADER_MARK_U  = 5'd16;
  localparam logic [4:0] LEADER_SPACE_U = 5'd8;
  localparam logic [4:0] ZERO_SPACE_U   = 5'd1;
  localparam logic [4:0] ONE_SPACE_U    = 5'd3;
  localparam logic [4:0] MARK_U         = 5'd1;

  function automatic logic is_mark(input ir_state_e s);
    return (s == LEADER_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

// File: rtl/pcihellocore_ir_transmitter_if.sv
// Avalon-MM slave bus of the IR transmitter, plus the FSM state as a debug view.
interface pcihellocore_ir_transmitter_if;
  import pcihellocore_ir_pkg::*;

  // Avalon-MM, no wait states: a write is accepted in every cycle with chipselect && !write_n;
  // readdata is registered and reflects the address presented one cycle earlier.
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  ir_state_e   fsm_state;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, fsm_state
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, fsm_state
  );

endinterface

// File: rtl/pcihellocore_ir_carrier_gen.sv
// Restartable 50% duty carrier divider; high for the first half of each CARRIER_DIV period.
module pcihellocore_ir_carrier_gen #(
  parameter int CARRIER_DIV = 1316
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic carrier
);

  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [CW-1:0] PHASE_LAST = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] PHASE_HALF = CW'(CARRIER_DIV / 2);

  logic [CW-1:0] phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
    end else if (restart || (phase == PHASE_LAST)) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign carrier = (phase < PHASE_HALF);

endmodule

// File: rtl/pcihellocore_ir_transmitter.sv
// NEC infrared frame transmitter on the pcihellocore Avalon-MM fabric.
// Define IR_TX_IRQ_EN to add the frame-done interrupt (irq port and STATUS bit2).
module pcihellocore_ir_transmitter
  import pcihellocore_ir_pkg::*;
#(
  parameter int UNIT_CYCLES = 28125,
  parameter int CARRIER_DIV = 1316,
  parameter int OUT_INVERT  = 0
) (
  input  logic clk,
  input  logic reset_n,
  pcihellocore_ir_transmitter_if.slave bus,
  output logic ir_out
`ifdef IR_TX_IRQ_EN
  ,
  output logic irq
`endif
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
  localparam logic INV = (OUT_INVERT != 0);

  ir_state_e     state, state_next;
  logic [UW-1:0] unit_cnt, unit_cnt_next;
  logic [4:0]    units_left, units_next;
  logic [4:0]    bit_idx, bit_idx_next;
  logic [31:0]   data_reg;
  logic [31:0]   rd_next;
  logic          overrun;
  logic          irq_pend;
  logic          busy;
  logic          data_wr, status_wr;
  logic          unit_done, state_done;
  logic          carrier, carrier_restart;
  logic          frame_done;

  assign data_wr    = bus.chipselect && !bus.write_n && (bus.address == REG_DATA);
  assign status_wr  = bus.chipselect && !bus.write_n && (bus.address == REG_STATUS);
  assign busy       = (state != IDLE);
  assign unit_done  = (unit_cnt == UNIT_LAST);
  assign state_done = unit_done && (units_left == 5'd0);
  assign frame_done = (state == STOP_MARK) && state_done;

  // Marks are never adjacent, so a mark entry is always a space/idle -> mark step.
  assign carrier_restart = !is_mark(state) && is_mark(state_next);

  always_comb begin
    state_next    = state;
    unit_cnt_next = unit_done ? '0 : unit_cnt + 1'b1;
    units_next    = units_left;
    bit_idx_next  = bit_idx;
    if (unit_done && (units_left != 5'd0)) begin
      units_next = units_left - 5'd1;
    end
    case (state)
      IDLE: begin
        unit_cnt_next = '0;
        if (data_wr) begin
          state_next   = LEADER_MARK;
          units_next   = LEADER_MARK_U - 5'd1;
          bit_idx_next = 5'd0;
        end
      end
      LEADER_MARK: begin
        if (state_done) begin
          state_next = LEADER_SPACE;
          units_next = LEADER_SPACE_U - 5'd1;
        end
      end
      LEADER_SPACE: begin
        if (state_done) begin
          state_next   = BIT_MARK;
          units_next   = MARK_U - 5'd1;
          bit_idx_next = 5'd0;
        end
      end
      BIT_MARK: begin
        if (state_done) begin
          state_next = BIT_SPACE;
          units_next = data_reg[bit_idx] ? (ONE_SPACE_U - 5'd1) : (ZERO_SPACE_U - 5'd1);
        end
      end
      BIT_SPACE: begin
        if (state_done) begin
          units_next = MARK_U - 5'd1;
          if (bit_idx == 5'd31) begin
            state_next = STOP_MARK;
          end else begin
            state_next   = BIT_MARK;
            bit_idx_next = bit_idx + 5'd1;
          end
        end
      end
      STOP_MARK: begin
        if (state_done) begin
          state_next = IDLE;
          units_next = 5'd0;
        end
      end
      default: begin
        state_next = IDLE;
        units_next = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      unit_cnt   <= '0;
      units_left <= 5'd0;
      bit_idx    <= 5'd0;
    end else begin
      state      <= state_next;
      unit_cnt   <= unit_cnt_next;
      units_left <= units_next;
      bit_idx    <= bit_idx_next;
    end
  end

  // Accepted words only; a write that lands while busy never disturbs the frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= 32'd0;
    end else if (data_wr && !busy) begin
      data_reg <= bus.writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (data_wr && busy) begin
      overrun <= 1'b1;
    end else if (status_wr && bus.writedata[STAT_OVERRUN]) begin
      overrun <= 1'b0;
    end
  end

`ifdef IR_TX_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_pend <= 1'b0;
    end else if (frame_done) begin
      irq_pend <= 1'b1;
    end else if (status_wr && bus.writedata[STAT_IRQ]) begin
      irq_pend <= 1'b0;
    end
  end
  assign irq = irq_pend;
`else
  logic frame_done_unused;
  assign frame_done_unused = frame_done;
  assign irq_pend = 1'b0;
`endif

  always_comb begin
    rd_next = 32'd0;
    case (bus.address)
      REG_DATA: rd_next = data_reg;
      REG_STATUS: begin
        rd_next[STAT_BUSY]    = busy;
        rd_next[STAT_OVERRUN] = overrun;
        rd_next[STAT_IRQ]     = irq_pend;
      end
      default: rd_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= 32'd0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

  pcihellocore_ir_carrier_gen #(
    .CARRIER_DIV(CARRIER_DIV)
  ) u_carrier (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (carrier_restart),
    .carrier (carrier)
  );

  // ir_out lags the FSM by one cycle, so the first mark cycle sees carrier phase 0 (high).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_out <= INV;
    end else begin
      ir_out <= is_mark(state) ? (carrier ^ INV) : INV;
    end
  end

  assign bus.fsm_state = state;

endmodule
